// File: rtl/ald_recipe_loader.sv
// ald_recipe_loader: decodes framed serial recipe bytes into preset writes and
// the start/stop handshake for the ALD ladder, answering each frame with ACK/NAK.
module ald_recipe_loader #(
  parameter int unsigned NUM_REGS      = 15,
  parameter logic [3:0]  CMD_ADDR      = 4'hF,
  parameter int unsigned TIMEOUT_TICKS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        start_serial,
  output logic        stop_req,
  input  logic        seq_done,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned TW      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]  SOF     = 8'hA5;
  localparam logic [7:0]  ACK     = 8'h06;
  localparam logic [7:0]  NAK     = 8'h15;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_HUNT, S_ADDR, S_D3, S_D2, S_D1, S_D0, S_CSUM, S_RESP
  } state_t;

  state_t        state;
  logic [7:0]    addr_q;
  logic [31:0]   data_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] tick_q;

  logic in_frame_c;
  logic timeout_c;
  logic frame_end_c;
  logic is_cmd_c;
  logic is_preset_c;
  logic csum_ok_c;
  logic ack_c;
  logic do_wr_c;
  logic do_start_c;
  logic do_stop_c;
  logic inc_err_c;

  // The ladder sees busy exactly when a run has been requested.
  assign busy = start_serial;

  // Frame-end decision: which action (if any) the completed frame triggers.
  always_comb begin
    in_frame_c  = (state != S_HUNT) && (state != S_RESP);
    timeout_c   = in_frame_c && !rx_valid && tick &&
                  (tick_q == TW'(TIMEOUT_TICKS - 1));
    frame_end_c = (state == S_CSUM) && rx_valid;
    is_cmd_c    = (addr_q == {4'h0, CMD_ADDR});
    is_preset_c = (32'(addr_q) < NUM_REGS);
    csum_ok_c   = (rx_data == csum_q);
    ack_c       = 1'b0;
    do_wr_c     = 1'b0;
    do_start_c  = 1'b0;
    do_stop_c   = 1'b0;
    if (csum_ok_c) begin
      if (is_cmd_c) begin
        if (data_q[1]) begin
          do_stop_c = 1'b1;
          ack_c     = 1'b1;
        end else if (data_q[0]) begin
          if (!start_serial) begin
            do_start_c = 1'b1;
            ack_c      = 1'b1;
          end
        end else begin
          ack_c = 1'b1;
        end
      end else if (is_preset_c && !start_serial) begin
        do_wr_c = 1'b1;
        ack_c   = 1'b1;
      end
    end
    inc_err_c = timeout_c || (frame_end_c && !ack_c);
  end

  // Frame FSM, response handshake, preset writes, run level and error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_HUNT;
      addr_q       <= 8'h00;
      data_q       <= 32'h0;
      csum_q       <= 8'h00;
      tick_q       <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= 8'h00;
      wr_en        <= 1'b0;
      wr_addr      <= 4'h0;
      wr_data      <= 32'h0;
      start_serial <= 1'b0;
      stop_req     <= 1'b0;
      err_cnt      <= 8'h00;
    end else begin
      wr_en    <= 1'b0;
      stop_req <= 1'b0;

      case (state)
        S_HUNT: begin
          if (rx_valid && (rx_data == SOF)) begin
            state  <= S_ADDR;
            csum_q <= 8'h00;
            data_q <= 32'h0;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data;
            csum_q <= csum_q ^ rx_data;
            state  <= S_D3;
          end
        end
        S_D3, S_D2, S_D1, S_D0: begin
          if (rx_valid) begin
            data_q <= {data_q[23:0], rx_data};
            csum_q <= csum_q ^ rx_data;
            state  <= state_t'(3'(state) + 3'd1);
          end
        end
        S_CSUM: begin
          if (rx_valid) begin
            state    <= S_RESP;
            tx_valid <= 1'b1;
            tx_data  <= ack_c ? ACK : NAK;
            stop_req <= do_stop_c;
            if (do_wr_c) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_q[3:0];
              wr_data <= data_q;
            end
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_HUNT;
          end
        end
        default: state <= S_HUNT;
      endcase

      // A stalled frame is abandoned silently.
      if (timeout_c) begin
        state <= S_HUNT;
      end

      // Inter-byte watchdog: only runs while inside a frame.
      if (!in_frame_c || rx_valid || timeout_c) begin
        tick_q <= '0;
      end else if (tick) begin
        tick_q <= tick_q + TW'(1);
      end

      // Start beats a coincident seq_done; stop or seq_done end the run.
      if (frame_end_c && do_start_c) begin
        start_serial <= 1'b1;
      end else if ((frame_end_c && do_stop_c) || seq_done) begin
        start_serial <= 1'b0;
      end

      if (inc_err_c && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ald_recipe_loader.sv
// Directed bench for ald_recipe_loader with response/write scoreboards.
module tb_ald_recipe_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start_serial;
  logic        stop_req;
  logic        seq_done = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [7:0] exp_resp[$];
  wr_t        exp_wr[$];
  int         vectors = 0;
  int         errs = 0;
  int         exp_err = 0;
  int         stop_cnt = 0;
  int         stop_before;

  ald_recipe_loader dut (
    .clk(clk), .rst(rst), .tick(tick), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start_serial(start_serial), .stop_req(stop_req), .seq_done(seq_done),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial forever #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: pop on each completed handshake.
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      if (exp_resp.size() == 0) begin
        vectors++;
        errs++;
        $error("FAIL tx_unexpected: observed %0h expected none", tx_data);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_resp.pop_front()});
      end
    end
  end

  // Write scoreboard and stop pulse counter.
  always @(negedge clk) begin
    if (rst && stop_req) stop_cnt++;
    if (rst && wr_en) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        errs++;
        $error("FAIL wr_unexpected: observed %0h/%0h expected none", wr_addr, wr_data);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", {28'h0, wr_addr}, {28'h0, w.a});
        check("wr_data", wr_data, w.d);
      end
    end
  end

  function automatic logic [7:0] csum_of(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic sd);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    seq_done = sd;
    @(negedge clk);
    rx_valid = 1'b0;
    seq_done = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 20 && exp_resp.size() != 0; i++) @(negedge clk);
    check("resp_drain", exp_resp.size(), 0);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] cs,
                            input logic [7:0] resp, input bit do_wr, input bit sd);
    wr_t w;
    send_byte(8'hA5, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d[31:24], 1'b0);
    send_byte(d[23:16], 1'b0);
    send_byte(d[15:8], 1'b0);
    send_byte(d[7:0], 1'b0);
    exp_resp.push_back(resp);
    if (do_wr) begin
      w.a = a[3:0];
      w.d = d;
      exp_wr.push_back(w);
    end
    if (resp == 8'h15) exp_err++;
    send_byte(cs, sd);
    check("tx_latency", {31'h0, tx_valid}, 32'h1);
    if (tx_ready) wait_resp();
  endtask

  function automatic logic [7:0] sat_err();
    return (exp_err > 255) ? 8'hFF : 8'(exp_err);
  endfunction

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    check("rst_wr_data", wr_data, 32'h0);
    check("rst_start", {31'h0, start_serial}, 32'h0);
    check("rst_stop", {31'h0, stop_req}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {24'h0, err_cnt}, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic preset write
    send_frame(8'h03, 32'h0000_03E8, 8'hE8, 8'h06, 1'b1, 1'b0);
    check("err_after_write", {24'h0, err_cnt}, 32'h0);
    check("wr_addr_hold", {28'h0, wr_addr}, 32'h3);
    check("wr_data_hold", wr_data, 32'h0000_03E8);

    // Stray bytes then bad checksum
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_frame(8'h03, 32'h0000_03E8, 8'h00, 8'h15, 1'b0, 1'b0);
    check("err_bad_csum", {24'h0, err_cnt}, 32'h1);

    // Start run
    send_frame(8'h0F, 32'h0000_0001, 8'h0E, 8'h06, 1'b0, 1'b0);
    check("start_set", {31'h0, start_serial}, 32'h1);
    check("busy_set", {31'h0, busy}, 32'h1);

    // Locked preset and repeated start while busy
    send_frame(8'h02, 32'h0000_0005, csum_of(8'h02, 32'h5), 8'h15, 1'b0, 1'b0);
    send_frame(8'h0F, 32'h0000_0001, 8'h0E, 8'h15, 1'b0, 1'b0);
    check("err_busy_naks", {24'h0, err_cnt}, 32'(sat_err()));
    check("wr_data_locked", wr_data, 32'h0000_03E8);

    // seq_done ends run
    @(negedge clk);
    seq_done = 1'b1;
    @(negedge clk);
    seq_done = 1'b0;
    check("seq_done_clear", {31'h0, start_serial}, 32'h0);
    check("seq_done_busy", {31'h0, busy}, 32'h0);

    // Start with coincident seq_done: start wins
    send_frame(8'h0F, 32'h0000_0001, 8'h0E, 8'h06, 1'b0, 1'b1);
    check("start_beats_done", {31'h0, start_serial}, 32'h1);

    // Stop command
    stop_before = stop_cnt;
    send_frame(8'h0F, 32'h0000_0002, 8'h0D, 8'h06, 1'b0, 1'b0);
    check("stop_pulse", stop_cnt - stop_before, 1);
    check("stop_clear", {31'h0, start_serial}, 32'h0);

    // Stop with coincident seq_done; bit1 beats bit0
    send_frame(8'h0F, 32'h0000_0001, 8'h0E, 8'h06, 1'b0, 1'b0);
    stop_before = stop_cnt;
    send_frame(8'h0F, 32'h0000_0003, 8'h0C, 8'h06, 1'b0, 1'b1);
    check("stop_done_pulse", stop_cnt - stop_before, 1);
    check("stop_done_clear", {31'h0, start_serial}, 32'h0);

    // Address boundaries and no-op command
    send_frame(8'h20, 32'h0, 8'h20, 8'h15, 1'b0, 1'b0);
    send_frame(8'h0F, 32'h0, 8'h0F, 8'h06, 1'b0, 1'b0);
    check("noop_cmd", {31'h0, start_serial}, 32'h0);
    send_frame(8'h0E, 32'h1234_5678, 8'h06, 8'h06, 1'b1, 1'b0);
    check("err_boundary", {24'h0, err_cnt}, 32'(sat_err()));

    // Inter-byte timeout
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 49; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
    check("no_timeout_49", {24'h0, err_cnt}, 32'(sat_err()));
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    exp_err++;
    @(negedge clk);
    check("timeout_err", {24'h0, err_cnt}, 32'(sat_err()));
    check("timeout_no_tx", {31'h0, tx_valid}, 32'h0);
    send_frame(8'h01, 32'h0000_0055, 8'h54, 8'h06, 1'b1, 1'b0);

    // Backpressure: response held, bytes dropped
    tx_ready = 1'b0;
    send_frame(8'h04, 32'hAABB_CCDD, 8'h04, 8'h06, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_tx_valid", {31'h0, tx_valid}, 32'h1);
      check("bp_tx_data", {24'h0, tx_data}, 32'h06);
      rx_valid = (i % 2 == 0);
      rx_data  = (i % 4 == 0) ? 8'hA5 : 8'h0F;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("bp_err", {24'h0, err_cnt}, 32'(sat_err()));
    tx_ready = 1'b1;
    wait_resp();
    check("bp_tx_drop", {31'h0, tx_valid}, 32'h0);
    send_frame(8'h05, 32'h0000_0009, 8'h0C, 8'h06, 1'b1, 1'b0);

    // Error counter saturation
    for (int i = 0; i < 255; i++) begin
      send_frame(8'h07, 32'h0, 8'h00, 8'h15, 1'b0, 1'b0);
      if (exp_err == 255) check("err_at_255", {24'h0, err_cnt}, 32'hFF);
    end
    check("err_saturated", {24'h0, err_cnt}, 32'hFF);

    // Reset mid-run and mid-frame
    send_frame(8'h0F, 32'h0000_0001, 8'h0E, 8'h06, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_start", {31'h0, start_serial}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_err", {24'h0, err_cnt}, 32'h0);
    check("mid_rst_wr_data", wr_data, 32'h0);
    check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    exp_err = 0;
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h76, 1'b0);
    repeat (3) @(negedge clk);
    check("post_rst_no_tx", {31'h0, tx_valid}, 32'h0);
    send_frame(8'h01, 32'h0000_0077, 8'h76, 8'h06, 1'b1, 1'b0);
    check("post_rst_err", {24'h0, err_cnt}, 32'h0);

    repeat (5) @(negedge clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("resp_queue_empty", exp_resp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
